// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = {borrow, A - B}, one bit per clock, LSB first.
// Computed as A + ~B + 1, so the carry is preset to 1 and borrow is the inverted final carry.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   diff_q, diff_d;

  logic             sb_inv;
  logic             bit_r;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    sb_inv    = ~sb_q[0];
    bit_r     = sa_q[0] ^ sb_inv ^ carry_q;
    carry_nxt = (sa_q[0] & sb_inv) | (carry_q & (sa_q[0] ^ sb_inv));
    res_shift = {bit_r, res_q};
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;

    unique case (state_q)
      // DONE samples start like IDLE so that a held start runs ops every WIDTH+1 cycles.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StRun;
          sa_d    = A;
          sb_d    = B;
          carry_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StRun: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        res_d   = res_shift[WIDTH-1:1];
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          diff_d  = {~carry_nxt, res_shift};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;

endmodule
